// File: rtl/key_expansion_function_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : key_expansion_function_pkg
// Brief    : Shared constants for the AES-128 key expansion: the S-box, the
//            round constants RC[1..10], the key width and the round count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package key_expansion_function_pkg;

  localparam int KEYEXP_WIDTH = 128;
  localparam int NUM_ROUNDS   = 10;

  // FIPS-197 forward S-box, indexed by the input byte
  localparam logic [7:0] C_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constants; round r XORs {C_RC[r], 24'h0} into its first word
  localparam logic [7:0] C_RC [1:NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // S-box applied independently to each byte of a 32-bit word
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {C_SBOX[w[31:24]], C_SBOX[w[23:16]], C_SBOX[w[15:8]], C_SBOX[w[7:0]]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_expansion_function_round.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : key_expansion_round
// Brief    : One combinational AES-128 key-schedule step: derives the next
//            four round-key words from the previous four and a round constant.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module key_expansion_round
  import key_expansion_function_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [31:0]  rcon_i,
  output logic [127:0] key_o
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot;
  logic [31:0] w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  // w0 is the most significant word of the previous key
  assign w_w0 = key_i[127:96];
  assign w_w1 = key_i[95:64];
  assign w_w2 = key_i[63:32];
  assign w_w3 = key_i[31:0];

  // RotWord moves the top byte to the bottom
  assign w_rot = {w_w3[23:0], w_w3[31:24]};
  assign w_t   = sub_word(w_rot) ^ rcon_i;

  // Each new word chains off the one before it
  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_n0 ^ w_w1;
  assign w_n2 = w_n1 ^ w_w2;
  assign w_n3 = w_n2 ^ w_w3;

  assign key_o = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/key_expansion_function.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : key_expansion_function
// Brief    : AES-128 key expansion. A ten-stage combinational round chain
//            feeds ten round-key registers that load on key_valid_i.
//            Optional macro KEYEXP_ZEROIZE_EN adds a synchronous zeroize_i
//            clear that takes priority over a load.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module key_expansion_function
  import key_expansion_function_pkg::*;
#(
  parameter int WIDTH = KEYEXP_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
`ifdef KEYEXP_ZEROIZE_EN
  input  logic             zeroize_i,
`endif
  input  logic             key_valid_i,
  input  logic [WIDTH-1:0] key_ciph_i,
  output logic [WIDTH-1:0] key_o_1,
  output logic [WIDTH-1:0] key_o_2,
  output logic [WIDTH-1:0] key_o_3,
  output logic [WIDTH-1:0] key_o_4,
  output logic [WIDTH-1:0] key_o_5,
  output logic [WIDTH-1:0] key_o_6,
  output logic [WIDTH-1:0] key_o_7,
  output logic [WIDTH-1:0] key_o_8,
  output logic [WIDTH-1:0] key_o_9,
  output logic [WIDTH-1:0] key_o_10,
  output logic             keys_valid_o
);

  // The schedule is defined for AES-128 only
  if (WIDTH != KEYEXP_WIDTH) begin : g_width_check
    $error("key_expansion_function: WIDTH must be 128");
  end

  logic [KEYEXP_WIDTH-1:0] w_round [0:NUM_ROUNDS];
  logic [WIDTH-1:0]        r_keys  [1:NUM_ROUNDS];
  logic                    r_keys_valid;

  assign w_round[0] = key_ciph_i;

  // Ten chained combinational rounds; stage r feeds stage r+1
  for (genvar gi = 1; gi <= NUM_ROUNDS; gi++) begin : g_round
    key_expansion_round u_round (
      .key_i  (w_round[gi-1]),
      .rcon_i ({C_RC[gi], 24'h0}),
      .key_o  (w_round[gi])
    );
  end

  // Capture the whole schedule on a load; hold otherwise; reset clears at once
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 1; r <= NUM_ROUNDS; r++) r_keys[r] <= '0;
      r_keys_valid <= 1'b0;
    end
`ifdef KEYEXP_ZEROIZE_EN
    else if (zeroize_i) begin
      for (int r = 1; r <= NUM_ROUNDS; r++) r_keys[r] <= '0;
      r_keys_valid <= 1'b0;
    end
`endif
    else if (key_valid_i) begin
      for (int r = 1; r <= NUM_ROUNDS; r++) r_keys[r] <= w_round[r];
      r_keys_valid <= 1'b1;
    end
  end

  assign key_o_1      = r_keys[1];
  assign key_o_2      = r_keys[2];
  assign key_o_3      = r_keys[3];
  assign key_o_4      = r_keys[4];
  assign key_o_5      = r_keys[5];
  assign key_o_6      = r_keys[6];
  assign key_o_7      = r_keys[7];
  assign key_o_8      = r_keys[8];
  assign key_o_9      = r_keys[9];
  assign key_o_10     = r_keys[10];
  assign keys_valid_o = r_keys_valid;

endmodule
`default_nettype wire

// File: tb/tb_key_expansion_function.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_key_expansion_function
// Brief    : Self-checking bench for key_expansion_function. The reference
//            builds the S-box from GF(2^8) inversion plus the affine map and
//            runs the textbook 44-word key expansion.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_key_expansion_function;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic [127:0] key_ciph;
  logic [127:0] ko [1:10];
  logic         keys_valid;
`ifdef KEYEXP_ZEROIZE_EN
  logic         zeroize;
`endif

  logic [127:0] rnd_key;
  logic [31:0]  rnd_rcon;
  logic [127:0] rnd_out;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]   m_sbox [256];
  logic [127:0] m_keys [1:10];

  typedef struct {
    logic [127:0] key;
    logic [127:0] k1;
    logic [127:0] k2;
    logic [127:0] k10;
  } vec_t;
  vec_t vecs [2];

  always #5 clk = ~clk;

  key_expansion_function dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
`ifdef KEYEXP_ZEROIZE_EN
    .zeroize_i    (zeroize),
`endif
    .key_valid_i  (key_valid),
    .key_ciph_i   (key_ciph),
    .key_o_1      (ko[1]),
    .key_o_2      (ko[2]),
    .key_o_3      (ko[3]),
    .key_o_4      (ko[4]),
    .key_o_5      (ko[5]),
    .key_o_6      (ko[6]),
    .key_o_7      (ko[7]),
    .key_o_8      (ko[8]),
    .key_o_9      (ko[9]),
    .key_o_10     (ko[10]),
    .keys_valid_o (keys_valid)
  );

  key_expansion_round u_rnd (
    .key_i  (rnd_key),
    .rcon_i (rnd_rcon),
    .key_o  (rnd_out)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} >> (8 - n);
    return t[7:0];
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      m_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 1; r <= 10; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare every output against the schedule of key k, or against zero
  task automatic check_outputs(input string name, input logic [127:0] k, input logic loaded);
    if (loaded) expand(k);
    for (int r = 1; r <= 10; r++)
      check($sformatf("%s key_o_%0d", name, r), ko[r], loaded ? m_keys[r] : 128'h0);
    check($sformatf("%s keys_valid_o", name), {127'h0, keys_valid}, {127'h0, loaded});
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Pulse key_valid for one edge; leaves the bench at the following negedge
  task automatic load(input logic [127:0] k);
    @(negedge clk);
    key_ciph  = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] k, last;

    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'hf2c295f27a96b9435935807a7359f67f,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{128'h0,
                128'h62636363626363636263636362636363,
                128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    build_sbox();

    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_ciph  = rand128();
    rnd_key   = 128'h0;
    rnd_rcon  = 32'h0;
`ifdef KEYEXP_ZEROIZE_EN
    zeroize   = 1'b0;
`endif

    // Reset state, then no capture without a load
    @(negedge clk);
    check_outputs("reset", 128'h0, 1'b0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      key_ciph = rand128();
    end
    @(negedge clk);
    check_outputs("post_reset_idle", 128'h0, 1'b0);

    // Standalone round: known vector, then random keys against model round 1
    rnd_key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rnd_rcon = 32'h01000000;
    #1;
    check("round_fips", rnd_out, 128'ha0fafe1788542cb123a339392a6c7605);
    for (int i = 0; i < 4; i++) begin
      rnd_key = rand128();
      #1;
      expand(rnd_key);
      check($sformatf("round_rand%0d", i), rnd_out, m_keys[1]);
    end

    // Known-answer table
    for (int v = 0; v < 2; v++) begin
      load(vecs[v].key);
      check($sformatf("vec%0d k1", v), ko[1], vecs[v].k1);
      check($sformatf("vec%0d k2", v), ko[2], vecs[v].k2);
      check($sformatf("vec%0d k10", v), ko[10], vecs[v].k10);
      check_outputs($sformatf("vec%0d", v), vecs[v].key, 1'b1);
    end

    // Hold: key input churns while key_valid is low
    last = vecs[1].key;
    repeat (4) begin
      @(negedge clk);
      key_ciph = rand128();
    end
    @(negedge clk);
    check_outputs("hold", last, 1'b1);

    // Back-to-back loads, one per edge
    @(negedge clk);
    key_ciph  = vecs[0].key;
    key_valid = 1'b1;
    @(negedge clk);
    check_outputs("b2b_first", vecs[0].key, 1'b1);
    key_ciph = vecs[1].key;
    @(negedge clk);
    check_outputs("b2b_second", vecs[1].key, 1'b1);
    key_valid = 1'b0;

    // Randomized loads with random idle gaps
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        key_ciph = rand128();
      end
      k = rand128();
      load(k);
      check_outputs($sformatf("rand%0d", i), k, 1'b1);
    end

    // Asynchronous reset mid-operation, observed before the next edge
    k = rand128();
    load(k);
    #2 rst_n = 1'b0;
    #1 check_outputs("async_reset", 128'h0, 1'b0);

    // Reset held across a load edge wins
    @(negedge clk);
    key_ciph  = rand128();
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check_outputs("reset_vs_load", 128'h0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("reset_release", 128'h0, 1'b0);

`ifdef KEYEXP_ZEROIZE_EN
    // Zeroize beats a simultaneous load
    k = rand128();
    load(k);
    check_outputs("pre_zeroize", k, 1'b1);
    @(negedge clk);
    zeroize   = 1'b1;
    key_valid = 1'b1;
    key_ciph  = rand128();
    @(negedge clk);
    zeroize   = 1'b0;
    key_valid = 1'b0;
    check_outputs("zeroize", 128'h0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_expansion_function.md
KEY_EXPANSION_FUNCTION -- requirements
Module: key_expansion_function

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, meaning the key and round-key width; only 128 is supported, and any other value SHALL be an elaboration error.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all registers update on its rising edge.
REQ-003 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port key_valid_i, input, 1 bit: load strobe for key_ciph_i.
REQ-005 The block SHALL have port key_ciph_i, input, WIDTH bits: AES-128 cipher key; byte 0 is bits [127:120].
REQ-006 The block SHALL have ports key_o_1 .. key_o_10, output, WIDTH bits each: round keys 1..10; word w[4r] is bits [127:96].
REQ-007 The block SHALL have port keys_valid_o, output, 1 bit: key_o_1..key_o_10 hold a complete schedule.

Function
REQ-008 Each round SHALL compute from previous key words w0..w3 (w0 = bits [127:96]): t = SubWord(RotWord(w3)) XOR rcon; n0 = w0^t; n1 = n0^w1; n2 = n1^w2; n3 = n2^w3.
REQ-009 RotWord SHALL be a cyclic left rotation by one byte: [a0,a1,a2,a3] becomes [a1,a2,a3,a0].
REQ-010 SubWord SHALL apply the FIPS-197 S-box to each of the four bytes.
REQ-011 Round r SHALL use rcon = {RC[r], 24'h0}, with RC[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 (hex).
REQ-012 Round 1 SHALL take key_ciph_i as its input; round r > 1 SHALL take the combinational result of round r-1.
REQ-013 The ten-round chain SHALL be purely combinational between key_ciph_i and the output registers.
REQ-014 On a rising edge with key_valid_i=1, all ten round keys SHALL be registered into key_o_1..key_o_10, and keys_valid_o SHALL be set to 1.
REQ-015 Load latency SHALL be exactly one cycle: outputs are valid in the cycle after key_valid_i is sampled high.
REQ-016 With key_valid_i=0, all outputs SHALL hold their values, and keys_valid_o SHALL stay as it is.
REQ-017 Back-to-back loads SHALL be accepted every cycle; each edge with key_valid_i=1 SHALL replace the whole schedule.
REQ-018 key_ciph_i changes while key_valid_i=0 SHALL have no effect on the outputs.

Reset
REQ-019 On rst_n_i=0, key_o_1..key_o_10 SHALL be cleared to 0 immediately (asynchronously), and keys_valid_o SHALL be cleared to 0.
REQ-020 On release of rst_n_i, outputs SHALL stay 0 until the first edge with key_valid_i=1.
REQ-021 Reset asserted in the same cycle as a load SHALL win; no key SHALL be captured.

Configuration
REQ-022 Macro KEYEXP_ZEROIZE_EN, when defined, SHALL add port zeroize_i, input, 1 bit, whose effect is a synchronous clear.
REQ-023 With KEYEXP_ZEROIZE_EN defined, a rising edge with zeroize_i=1 SHALL set all round-key registers and keys_valid_o to 0.
REQ-024 With KEYEXP_ZEROIZE_EN defined, zeroize_i SHALL have priority over key_valid_i when both are high.
REQ-025 Without KEYEXP_ZEROIZE_EN, the zeroize_i port and its logic SHALL be absent.

Structure
REQ-026 The shared package SHALL hold the 256-entry S-box constant, the RC[1..10] constant array, and the WIDTH=128 localparam.
REQ-027 The per-round transform SHALL be sub-module key_expansion_round, combinational, with ports key_i (128), rcon_i (32) and key_o (128).
REQ-028 key_expansion_function SHALL instantiate key_expansion_round ten times in a generate loop.

Verification
REQ-029 The bench SHALL cover the FIPS-197 A.1 key: load key_ciph_i=2b7e151628aed2a6abf7158809cf4f3c with key_valid_i=1 -> one cycle later key_o_1=a0fafe1788542cb123a339392a6c7605, key_o_2=f2c295f27a96b9435935807a7359f67f, key_o_10=d014f9a8c9ee2589e13f0cc8b6630ca6, keys_valid_o=1.
REQ-030 The bench SHALL cover the all-zero key: load 0 -> key_o_1=62636363626363636263636362636363, key_o_10=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-031 The bench SHALL cover key_expansion_round standalone: key_i=2b7e151628aed2a6abf7158809cf4f3c, rcon_i=01000000 -> key_o=a0fafe1788542cb123a339392a6c7605.
REQ-032 The bench SHALL cover hold behaviour: change key_ciph_i with key_valid_i=0 -> outputs unchanged; load the FIPS key, then the zero key on consecutive cycles -> outputs follow each load with 1-cycle latency.
REQ-033 The bench SHALL cover reset mid-operation: assert rst_n_i=0 asynchronously after a load -> all key_o_* become 0 and keys_valid_o becomes 0 before the next clock edge.
REQ-034 The bench SHALL cover zeroize with KEYEXP_ZEROIZE_EN defined: zeroize_i=1 together with key_valid_i=1 -> next edge all key_o_* are 0 and keys_valid_o is 0.
